// File: rtl/fp_rnd_pipe.sv
// Two-stage IEEE-754 single rounding/packing stage with valid/ready flow.
// S1 captures the bundle plus round decision; S2 holds the packed result.
module fp_rnd_pipe (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sig,
    input  logic [10:0] expo,
    input  logic [24:0] mant,
    input  logic [1:0]  rema,
    input  logic [1:0]  fmt,
    input  logic [2:0]  rm,
    input  logic [2:0]  grs,
    input  logic        snan,
    input  logic        qnan,
    input  logic        dbz,
    input  logic        inf,
    input  logic        zero,
    input  logic        diff,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    typedef struct packed {
        logic        sig;
        logic [10:0] expo;
        logic [24:0] mant;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
        logic        diff;
        logic        inexact;
        logic        up;
    } s1_t;

    s1_t  s1_q;
    s1_t  s1_d;
    logic s1_valid;
    logic s2_valid;
    logic rst_done;
    logic s1_adv;
    logic s2_adv;
    logic s1_load;
    logic s2_load;
    logic inexact_c;
    logic up_c;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv & rst_done;
    assign s1_load   = in_valid & in_ready;
    assign s2_load   = s2_adv & s1_valid;
    assign out_valid = s2_valid;

    // Round-up decision; encodings 5-7 fall through to nearest-even.
    always_comb begin
        inexact_c = (|grs) | (|rema);
        up_c      = 1'b0;
        case (rm)
            RTZ:     up_c = 1'b0;
            RDN:     up_c = sig & inexact_c;
            RUP:     up_c = ~sig & inexact_c;
            RMM:     up_c = grs[2];
            default: up_c = grs[2] & (grs[1] | grs[0] | mant[0]);
        endcase
    end

    always_comb begin
        s1_d.sig     = sig;
        s1_d.expo    = expo;
        s1_d.mant    = mant;
        s1_d.fmt     = fmt;
        s1_d.rm      = rm;
        s1_d.snan    = snan;
        s1_d.qnan    = qnan;
        s1_d.dbz     = dbz;
        s1_d.inf     = inf;
        s1_d.zero    = zero;
        s1_d.diff    = diff;
        s1_d.inexact = inexact_c;
        s1_d.up      = up_c;
    end

    logic [24:0] mant_r;
    logic [10:0] exp_r;
    logic [22:0] frac;
    logic        max_fin;
    logic [31:0] res_c;
    logic [4:0]  flg_c;

    always_comb begin
        mant_r = s1_q.mant + {24'd0, s1_q.up};
        exp_r  = s1_q.expo;
        frac   = mant_r[22:0];
        if (mant_r[24]) begin
            exp_r = s1_q.expo + 11'd1;
            frac  = 23'd0;
        end else if (s1_q.expo == 11'd0 && mant_r[23]) begin
            exp_r = 11'd1;
        end
        max_fin = (s1_q.rm == RTZ)
                | ((s1_q.rm == RDN) & ~s1_q.sig)
                | ((s1_q.rm == RUP) & s1_q.sig);
        res_c = {s1_q.sig, exp_r[7:0], frac};
        flg_c = {4'b0000, s1_q.inexact};
        if (exp_r >= 11'd255) begin
            res_c = max_fin ? {s1_q.sig, 8'hFE, 23'h7FFFFF}
                            : {s1_q.sig, 8'hFF, 23'h0};
            flg_c = 5'b00101;
        end else if (exp_r == 11'd0 && s1_q.inexact) begin
            flg_c = 5'b00011;
        end
        // Specials in priority order override the rounded value.
        if (s1_q.fmt != 2'd0) begin
            res_c = 32'h7FC00000;
            flg_c = 5'b10000;
        end else if (s1_q.snan) begin
            res_c = 32'h7FC00000;
            flg_c = 5'b10000;
        end else if (s1_q.qnan) begin
            res_c = 32'h7FC00000;
            flg_c = 5'b00000;
        end else if (s1_q.dbz) begin
            res_c = {s1_q.sig, 8'hFF, 23'h0};
            flg_c = 5'b01000;
        end else if (s1_q.inf) begin
            res_c = {s1_q.sig, 8'hFF, 23'h0};
            flg_c = 5'b00000;
        end else if (s1_q.zero) begin
            res_c = {s1_q.diff ? (s1_q.rm == RDN) : s1_q.sig, 31'h0};
            flg_c = 5'b00000;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_done <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (s1_adv)
                s1_valid <= s1_load;
            if (s2_adv)
                s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
        end else if (s1_load) begin
            s1_q <= s1_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result <= 32'd0;
            flags  <= 5'd0;
        end else if (s2_load) begin
            result <= res_c;
            flags  <= flg_c;
        end
    end

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed bench for fp_rnd_pipe: rounding vectors, specials,
// backpressure ordering and mid-stream reset.
module tb_fp_rnd_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        sig;
    logic [10:0] expo;
    logic [24:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan, qnan, dbz, inf, zero, diff;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fp_rnd_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sig       (sig),
        .expo      (expo),
        .mant      (mant),
        .rema      (rema),
        .fmt       (fmt),
        .rm        (rm),
        .grs       (grs),
        .snan      (snan),
        .qnan      (qnan),
        .dbz       (dbz),
        .inf       (inf),
        .zero      (zero),
        .diff      (diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct packed {
        logic        s;
        logic [10:0] e;
        logic [24:0] m;
        logic [1:0]  rem;
        logic [1:0]  f;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [5:0]  sp;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    vec_t tv[$];
    logic [36:0] exp_q[$];

    function automatic vec_t mk(logic s, logic [10:0] e, logic [24:0] m,
                                logic [1:0] rem, logic [1:0] f,
                                logic [2:0] r, logic [2:0] g,
                                logic [5:0] sp, logic [31:0] res,
                                logic [4:0] fl);
        vec_t v;
        v.s = s; v.e = e; v.m = m; v.rem = rem; v.f = f;
        v.r = r; v.g = g; v.sp = sp; v.res = res; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic apply(input vec_t v);
        sig  = v.s;
        expo = v.e;
        mant = v.m;
        rema = v.rem;
        fmt  = v.f;
        rm   = v.r;
        grs  = v.g;
        {snan, qnan, dbz, inf, zero, diff} = v.sp;
    endtask

    task automatic run_one(input vec_t v, input int idx);
        @(negedge clock);
        apply(v);
        in_valid = 1'b1;
        chk($sformatf("v%0d_rdy", idx), 64'(in_ready), 64'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        chk($sformatf("v%0d_lat1", idx), 64'(out_valid), 64'd0);
        @(posedge clock);
        #1;
        chk($sformatf("v%0d_ov", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_res", idx), 64'({result, flags}),
            64'({v.res, v.fl}));
    endtask

    // sp = {snan, qnan, dbz, inf, zero, diff}; flags = {NV,DZ,OF,UF,NX}
    initial begin
        tv.push_back(mk(0, 127, 25'h800000, 0, 0, 0, 3'b000, 0, 32'h3F800000, 5'h00));
        tv.push_back(mk(0, 127, 25'h800001, 0, 0, 0, 3'b100, 0, 32'h3F800002, 5'h01));
        tv.push_back(mk(0, 127, 25'h800000, 0, 0, 0, 3'b100, 0, 32'h3F800000, 5'h01));
        tv.push_back(mk(0, 127, 25'h800000, 0, 0, 4, 3'b100, 0, 32'h3F800001, 5'h01));
        tv.push_back(mk(0, 127, 25'hFFFFFF, 0, 0, 0, 3'b110, 0, 32'h40000000, 5'h01));
        tv.push_back(mk(0, 0,   25'h7FFFFF, 0, 0, 0, 3'b110, 0, 32'h00800000, 5'h01));
        tv.push_back(mk(0, 0,   25'h000001, 0, 0, 1, 3'b001, 0, 32'h00000001, 5'h03));
        tv.push_back(mk(0, 254, 25'hFFFFFF, 0, 0, 0, 3'b100, 0, 32'h7F800000, 5'h05));
        tv.push_back(mk(0, 254, 25'hFFFFFF, 0, 0, 1, 3'b100, 0, 32'h7F7FFFFF, 5'h01));
        tv.push_back(mk(1, 254, 25'hFFFFFF, 0, 0, 3, 3'b100, 0, 32'hFF7FFFFF, 5'h01));
        tv.push_back(mk(0, 255, 25'h800000, 0, 0, 1, 3'b000, 0, 32'h7F7FFFFF, 5'h05));
        tv.push_back(mk(1, 255, 25'h800000, 0, 0, 3, 3'b000, 0, 32'hFF7FFFFF, 5'h05));
        tv.push_back(mk(1, 255, 25'h800000, 0, 0, 0, 3'b000, 0, 32'hFF800000, 5'h05));
        tv.push_back(mk(0, 127, 25'h800000, 0, 0, 0, 3'b000, 6'h20, 32'h7FC00000, 5'h10));
        tv.push_back(mk(1, 127, 25'h800000, 0, 0, 0, 3'b000, 6'h08, 32'hFF800000, 5'h08));
        tv.push_back(mk(0, 0,   25'h000000, 0, 0, 2, 3'b000, 6'h03, 32'h80000000, 5'h00));
        tv.push_back(mk(1, 0,   25'h000000, 0, 0, 0, 3'b000, 6'h03, 32'h00000000, 5'h00));
        tv.push_back(mk(0, 127, 25'h800000, 0, 0, 0, 3'b000, 6'h24, 32'h7FC00000, 5'h10));
        tv.push_back(mk(0, 127, 25'h800000, 0, 1, 0, 3'b000, 0, 32'h7FC00000, 5'h10));
        tv.push_back(mk(0, 127, 25'h800000, 0, 0, 0, 3'b111, 6'h10, 32'h7FC00000, 5'h00));
        tv.push_back(mk(0, 127, 25'h800000, 1, 0, 3, 3'b000, 0, 32'h3F800001, 5'h01));
        tv.push_back(mk(0, 127, 25'h800001, 0, 0, 5, 3'b100, 0, 32'h3F800002, 5'h01));
        tv.push_back(mk(1, 10,  25'h800000, 0, 0, 0, 3'b000, 6'h04, 32'hFF800000, 5'h00));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel[5] = '{1, 4, 7, 14, 20};
        int stall_acc;
        int got;
        int seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        apply('0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_flg", 64'(flags), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1 chk("rdy_after_rst", 64'(in_ready), 64'd1);

        for (int i = 0; i < tv.size(); i++)
            run_one(tv[i], i);
        @(posedge clock);
        #1;
        @(negedge clock) out_ready = 1'b0;
        @(posedge clock);
        #1;

        stall_acc = 99;
        got = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    bit r;
                    int tries;
                    @(negedge clock);
                    apply(tv[sel[k]]);
                    in_valid = 1'b1;
                    tries = 0;
                    r = 1'b0;
                    while (!r && tries < 50) begin
                        r = in_ready;
                        if (!r && stall_acc == 99)
                            stall_acc = k;
                        @(posedge clock);
                        if (!r)
                            @(negedge clock);
                        tries++;
                    end
                    if (r)
                        exp_q.push_back({tv[sel[k]].res, tv[sel[k]].fl});
                    else
                        chk("bp_accept_timeout", 64'd0, 64'd1);
                end
                #1 in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (got < 5 && cyc < 80) begin
                    @(negedge clock);
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("bp_extra", 64'd1, 64'd0);
                        end else begin
                            chk($sformatf("bp%0d", got), 64'({result, flags}),
                                64'(exp_q.pop_front()));
                        end
                        got++;
                    end
                end
            end
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        chk("bp_stall_after", 64'(stall_acc), 64'd2);
        chk("bp_count", 64'(got), 64'd5);

        @(posedge clock);
        #1 out_ready = 1'b0;
        apply(tv[1]);
        in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 chk("mid_full_ov", 64'(out_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_res", 64'(result), 64'd0);
        chk("mid_rst_flg", 64'(flags), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        #1 chk("rel_rdy0", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1 chk("rel_rdy1", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid)
                seen++;
        end
        chk("no_stale", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
